timer_share_arb: RTL and testbench

- Arbitrates one loadable interval counter among N_REQ requesters; each requester asks for a timed interval of a given tick length.
- Round-robin grant; latches the winner's duration as the terminal value, runs the counter, pulses that requester's done at terminal count.
- Sits between control FSMs needing delays/timeouts and a single shared 16-bit counter datapath.

---
 rtl/timer_share_pkg.sv | 14 +
 rtl/timer_share_arb_tick_counter.sv | 31 +++
 rtl/timer_share_arb.sv | 134 +++++++++++++
 tb/tb_timer_share_arb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_share_pkg.sv
// Shared types and defaults for the timer_share_arb block.
package timer_share_pkg;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/timer_share_arb_tick_counter.sv
// Loadable up-counter: clears and latches a terminal value on load, then
// counts inc pulses until it matches the terminal value, where it halts.
module tick_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             hit
);

   logic [WIDTH-1:0] term;

   assign hit = (count == term);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         term  <= '0;
      end else if (load) begin
         count <= '0;
         term  <= load_val;
      end else if (inc && !hit) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/timer_share_arb.sv
// Round-robin arbiter sharing one interval counter among N_REQ requesters.
// Define TIMER_SHARE_ARB_PRESCALE_EN to divide counter ticks by PRESCALE.
module timer_share_arb
   import timer_share_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PRESCALE = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   dur,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         done,
   output logic                     busy,
   output logic [WIDTH-1:0]         count,
   output logic [$clog2(N_REQ)-1:0] cur_id
);

   localparam int IDW = $clog2(N_REQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

   state_t         state, state_n;
   logic [IDW-1:0] cur_id_n, rr, rr_n, sel, next_ptr;
   logic           any_req, load, inc, tick, hit;
   int             idx;

   // Walk offsets high to low so the nearest requester at/after rr wins.
   always_comb begin
      sel     = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr) + k) % N_REQ;
         if (req[idx]) begin
            sel     = idx[IDW-1:0];
            any_req = 1'b1;
         end
      end
   end

   assign next_ptr = (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;

   always_comb begin
      state_n  = state;
      cur_id_n = cur_id;
      rr_n     = rr;
      load     = 1'b0;
      inc      = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_n  = LOAD;
               cur_id_n = sel;
            end
         end
         LOAD, RUN: begin
            if (!req[cur_id]) begin
               // Abort still rotates priority so the aborter goes to the back.
               state_n  = IDLE;
               rr_n     = next_ptr;
               cur_id_n = '0;
            end else if (state == LOAD) begin
               load    = 1'b1;
               state_n = RUN;
            end else if (hit) begin
               state_n = DONE;
            end else begin
               inc = tick;
            end
         end
         DONE: begin
            state_n  = IDLE;
            rr_n     = next_ptr;
            cur_id_n = '0;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cur_id <= '0;
         rr     <= '0;
      end else begin
         state  <= state_n;
         cur_id <= cur_id_n;
         rr     <= rr_n;
      end
   end

   assign busy = (state != IDLE);
   assign gnt  = busy ? (N_REQ'(1) << cur_id) : '0;
   assign done = (state == DONE) ? (N_REQ'(1) << cur_id) : '0;

`ifdef TIMER_SHARE_ARB_PRESCALE_EN
   localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

   logic [PSW-1:0] pre;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
      end else if (load) begin
         pre <= '0;
      end else if (state == RUN && en && !hit && req[cur_id]) begin
         pre <= (pre == PS_LAST) ? '0 : pre + 1'b1;
      end
   end

   assign tick = en && (pre == PS_LAST);
`else
   logic unused_prescale;
   assign unused_prescale = (PRESCALE > 0);
   assign tick            = en;
`endif

   tick_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (dur[int'(cur_id)*WIDTH +: WIDTH]),
      .inc      (inc),
      .count    (count),
      .hit      (hit)
   );

endmodule

// File: tb/tb_timer_share_arb.sv
// Scoreboard bench for timer_share_arb: grants and done pulses are predicted
// at stimulus time and checked by an independent monitor.
module tb_timer_share_arb;

   localparam int N_REQ    = 4;
   localparam int WIDTH    = 16;
   localparam int PRESCALE = 4;
`ifdef TIMER_SHARE_ARB_PRESCALE_EN
   localparam int MULT = PRESCALE;
`else
   localparam int MULT = 1;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   en;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] dur;
   logic [N_REQ-1:0]       gnt;
   logic [N_REQ-1:0]       done;
   logic                   busy;
   logic [WIDTH-1:0]       count;
   logic [1:0]             cur_id;

   timer_share_arb #(
      .N_REQ    (N_REQ),
      .WIDTH    (WIDTH),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .req    (req),
      .dur    (dur),
      .gnt    (gnt),
      .done   (done),
      .busy   (busy),
      .count  (count),
      .cur_id (cur_id)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int id; int cnt; int cyc;} done_t;
   typedef struct {int id; int cyc;} gnt_t;
   done_t done_q[$];
   gnt_t  gnt_q[$];

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: grant rising edges and done pulses are matched against the queues.
   logic [N_REQ-1:0] prev_gnt = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt != 0 && prev_gnt == 0) begin
            if (gnt_q.size() == 0) chk("unexpected_gnt", gnt, 0);
            else begin
               automatic gnt_t g = gnt_q.pop_front();
               chk("gnt_vec", gnt, 64'd1 << g.id);
               chk("gnt_cur_id", cur_id, g.id);
               chk("gnt_cycle", cyc, g.cyc);
            end
         end
         if (done != 0) begin
            if (done_q.size() == 0) chk("unexpected_done", done, 0);
            else begin
               automatic done_t d = done_q.pop_front();
               chk("done_vec", done, 64'd1 << d.id);
               chk("done_count", count, d.cnt);
               chk("done_cycle", cyc, d.cyc);
            end
         end
      end
      prev_gnt = gnt;
   end

   task automatic set_dur(input int id, input int d);
      dur[id*WIDTH +: WIDTH] = WIDTH'(d);
   endtask

   // Raise req[id] just after a rising edge and predict grant/done timing.
   task automatic start(input int id, input int d, input bit expect_done);
      @(posedge clk);
      #1;
      set_dur(id, d);
      req[id] = 1'b1;
      gnt_q.push_back('{id, cyc + 1});
      if (expect_done) done_q.push_back('{id, d, cyc + 3 + d * MULT});
   endtask

   task automatic wait_done(input int id);
      bit seen = 1'b0;
      for (int n = 0; n < 600 && !seen; n++) begin
         @(negedge clk);
         if (done[id]) seen = 1'b1;
      end
      if (!seen) chk("timeout_done", 0, 1);
   endtask

   task automatic wait_count(input int v);
      bit seen = 1'b0;
      for (int n = 0; n < 800 && !seen; n++) begin
         @(negedge clk);
         if (count == WIDTH'(v)) seen = 1'b1;
      end
      if (!seen) chk("timeout_count", count, v);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      req = '0;
      dur = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_cur_id", cur_id, 0);
      rst = 1'b0;

      // Reset mid-RUN: outputs clear immediately, no done.
      start(0, 100, 1'b0);
      wait_count(40);
      rst = 1'b1;
      #1;
      chk("midrst_gnt", gnt, 0);
      chk("midrst_done", done, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_count", count, 0);
      chk("midrst_cur_id", cur_id, 0);
      req = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single request, duration 5.
      start(1, 5, 1'b1);
      wait_done(1);
      req[1] = 1'b0;

      // Zero duration.
      start(2, 0, 1'b1);
      wait_done(2);
      req[2] = 1'b0;

      // Abort at count 10: counter holds, no done.
      start(3, 50, 1'b0);
      wait_count(10);
      req[3] = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_gnt", gnt, 0);
      chk("abort_count", count, 10);
      chk("abort_cur_id", cur_id, 0);
      repeat (4) @(negedge clk);

      // Round robin with all requesters pending; search restarts at 0.
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) set_dur(i, 2);
      req = '1;
      for (int n = 0; n < 5; n++) begin
         automatic int g = cyc + 1 + n * (4 + 2 * MULT);
         gnt_q.push_back('{n % N_REQ, g});
         done_q.push_back('{n % N_REQ, 2, g + 2 + 2 * MULT});
      end
      for (int n = 0; n < 5; n++) wait_done(n % N_REQ);
      req = '0;

      // en toggling 1,0,1,0... with duration 4.
      @(posedge clk);
      #1;
      set_dur(1, 4);
      req[1] = 1'b1;
      en     = 1'b1;
      gnt_q.push_back('{1, cyc + 1});
      done_q.push_back('{1, 4, (MULT == 1) ? cyc + 10 : cyc + 2 + 8 * MULT});
      begin
         bit seen = 1'b0;
         for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (done[1]) seen = 1'b1;
            else begin
               @(posedge clk);
               #1;
               en = ~en;
            end
         end
         if (!seen) chk("timeout_en_toggle", 0, 1);
      end
      en     = 1'b1;
      req[1] = 1'b0;

      repeat (6) @(negedge clk);
      chk("gnt_queue_empty", gnt_q.size(), 0);
      chk("done_queue_empty", done_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
